// File: rtl/fifo_pkg.sv
// =============================================================================
// Module : fifo_pkg
// Desc   : Shared operation encoding and sizing helpers for the flagged FIFO.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package fifo_pkg;

    // Bit 1 = read accepted, bit 0 = write accepted
    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_BOTH = 2'd3
    } fifo_op_e;

    localparam int c_default_ae_level = 2;

    // Level must be able to hold 0..DEPTH inclusive
    function automatic int level_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_regfile.sv
// =============================================================================
// Module : fifo_regfile
// Desc   : DATA_W x 2**ADDR_W storage, synchronous write, asynchronous read.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module fifo_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_flags.sv
// =============================================================================
// Module : fifo_flags
// Desc   : Show-ahead FIFO with registered level, full/empty and threshold flags.
//          Define FIFO_FLAGS_ERR_EN to add sticky overflow/underflow flags.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module fifo_flags
    import fifo_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int ADDR_W   = 4,
    parameter  int AF_LEVEL = fifo_depth(ADDR_W) - 2,
    parameter  int AE_LEVEL = c_default_ae_level,
    localparam int LEVEL_W  = level_width(ADDR_W)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr,
    input  logic [DATA_W-1:0]  w_data,
    input  logic               rd,
    output logic [DATA_W-1:0]  r_data,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [LEVEL_W-1:0] level
`ifdef FIFO_FLAGS_ERR_EN
    ,
    input  logic               err_clr,
    output logic               overflow,
    output logic               underflow
`endif
);

    localparam logic [LEVEL_W-1:0] c_depth    = LEVEL_W'(fifo_depth(ADDR_W));
    localparam logic [LEVEL_W-1:0] c_af_level = LEVEL_W'(AF_LEVEL);
    localparam logic [LEVEL_W-1:0] c_ae_level = LEVEL_W'(AE_LEVEL);
    localparam logic [LEVEL_W-1:0] c_one      = LEVEL_W'(1);

    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic               r_full;
    logic               r_empty;
    logic               r_almost_full;
    logic               r_almost_empty;

    logic               w_rd_ok;
    logic               w_wr_ok;
    fifo_op_e           w_op;
    logic [LEVEL_W-1:0] w_level_next;

    // A full FIFO is never empty, so a concurrent read frees the slot being written
    assign w_rd_ok = rd && !r_empty;
    assign w_wr_ok = wr && (!r_full || w_rd_ok);
    assign w_op    = fifo_op_e'({w_rd_ok, w_wr_ok});

    always_comb begin
        w_level_next = r_level;
        case (w_op)
            OP_PUSH: w_level_next = r_level + c_one;
            OP_POP:  w_level_next = r_level - c_one;
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_level        <= w_level_next;
            r_full         <= (w_level_next == c_depth);
            r_empty        <= (w_level_next == '0);
            r_almost_full  <= (w_level_next >= c_af_level);
            r_almost_empty <= (w_level_next <= c_ae_level);
        end
    end

    fifo_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (r_data)
    );

    assign level        = r_level;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;

`ifdef FIFO_FLAGS_ERR_EN
    logic r_overflow;
    logic r_underflow;
    logic w_ovf_set;
    logic w_udf_set;

    assign w_ovf_set = wr && !w_wr_ok;
    assign w_udf_set = rd && r_empty;

    // A new error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_set || (r_overflow  && !err_clr);
            r_underflow <= w_udf_set || (r_underflow && !err_clr);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_flags.sv
// =============================================================================
// Module : tb_fifo_flags
// Desc   : Self-checking bench for fifo_flags (DEPTH 4) against a queue model.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_fifo_flags;

    localparam int c_depth = 4;

    logic       clk;
    logic       reset_n;
    logic       wr;
    logic       rd;
    logic       err_clr;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] level;
`ifdef FIFO_FLAGS_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: a plain queue of stored words plus sticky error bits
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_udf;

    fifo_flags #(
        .DATA_W   (8),
        .ADDR_W   (2),
        .AF_LEVEL (3),
        .AE_LEVEL (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level)
`ifdef FIFO_FLAGS_ERR_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_update(input bit w, input bit r, input logic [7:0] d, input bit c);
        int  n;
        bit  ar;
        bit  aw;
        n  = mq.size();
        ar = r && (n > 0);
        aw = w && ((n < c_depth) || ar);
        m_ovf = (w && !aw) || (m_ovf && !c);
        m_udf = (r && (n == 0)) || (m_udf && !c);
        if (ar) mq.delete(0);
        if (aw) mq.push_back(d);
    endtask

    // Called just after a falling edge; returns just after the next falling edge
    task automatic step(input bit w, input bit r, input logic [7:0] d, input bit c);
        wr      = w;
        rd      = r;
        w_data  = d;
        err_clr = c;
        @(posedge clk);
        model_update(w, r, d, c);
        @(negedge clk);
        #1;
        wr      = 1'b0;
        rd      = 1'b0;
        err_clr = 1'b0;
    endtask

    // Asynchronous reset asserted between edges, checked before any clock edge
    task automatic mid_reset();
        reset_n = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        int n;
        n = mq.size();
        chk("level",        32'(level),        32'(n));
        chk("full",         32'(full),         32'(n == c_depth));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("almost_full",  32'(almost_full),  32'(n >= 3));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
        if (n > 0) chk("r_data", 32'(r_data), 32'(mq[0]));
`ifdef FIFO_FLAGS_ERR_EN
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
`endif
    end

    initial begin
        logic [7:0] drain_exp [4];
        bit         w;
        bit         r;
        bit         c;
        reset_n = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        err_clr = 1'b0;
        w_data  = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_level", 32'(level),        32'd0);
        chk("reset_empty", 32'(empty),        32'd1);
        chk("reset_ae",    32'(almost_empty), 32'd1);
        chk("reset_full",  32'(full),         32'd0);
        chk("reset_af",    32'(almost_full),  32'd0);
        reset_n = 1'b1;

        // Fill to full
        step(1, 0, 8'h11, 0); chk("fill1_level", 32'(level), 32'd1);
        step(1, 0, 8'h22, 0); chk("fill2_level", 32'(level), 32'd2);
        chk("fill2_af", 32'(almost_full), 32'd0);
        step(1, 0, 8'h33, 0); chk("fill3_level", 32'(level), 32'd3);
        chk("fill3_af", 32'(almost_full), 32'd1);
        step(1, 0, 8'h44, 0); chk("fill4_level", 32'(level), 32'd4);
        chk("fill4_full", 32'(full), 32'd1);
        chk("fill4_rdata", 32'(r_data), 32'h11);

        // Write refused while full
        step(1, 0, 8'h55, 0);
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_rdata", 32'(r_data), 32'h11);
`ifdef FIFO_FLAGS_ERR_EN
        chk("ovf_flag", 32'(overflow), 32'd1);
        step(0, 0, 8'h00, 1);
        chk("ovf_clr", 32'(overflow), 32'd0);
`endif

        // Simultaneous read/write while full, then drain across the wrap
        step(1, 1, 8'h55, 0);
        chk("rw_full_rdata", 32'(r_data), 32'h22);
        chk("rw_full_level", 32'(level),  32'd4);
        chk("rw_full_full",  32'(full),   32'd1);
        drain_exp = '{8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 4; i++) begin
            chk("drain_rdata", 32'(r_data), 32'(drain_exp[i]));
            step(0, 1, 8'h00, 0);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Simultaneous read/write while empty
        step(1, 1, 8'hA5, 0);
        chk("rw_empty_level", 32'(level),  32'd1);
        chk("rw_empty_rdata", 32'(r_data), 32'hA5);
        chk("rw_empty_empty", 32'(empty),  32'd0);
`ifdef FIFO_FLAGS_ERR_EN
        chk("udf_flag", 32'(underflow), 32'd1);
        step(0, 0, 8'h00, 1);
        chk("udf_clr", 32'(underflow), 32'd0);
`endif

        // Reset with words stored
        step(1, 0, 8'hB6, 0);
        step(1, 0, 8'hC7, 0);
        chk("pre_rst_level", 32'(level), 32'd3);
        mid_reset();
        step(1, 0, 8'h77, 0);
        chk("post_rst_rdata", 32'(r_data), 32'h77);
        chk("post_rst_level", 32'(level),  32'd1);

        // Randomized traffic, alternating write-heavy and read-heavy phases
        for (int i = 0; i < 600; i++) begin
            bit heavy_wr;
            heavy_wr = ((i / 40) % 2) == 0;
            w = $urandom_range(0, 99) < (heavy_wr ? 75 : 30);
            r = $urandom_range(0, 99) < (heavy_wr ? 30 : 75);
            c = $urandom_range(0, 11) == 0;
            step(w, r, 8'($urandom), c);
            if (i == 300) mid_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
